// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-side link.
// Holds the line FSM state type, frame constants and frame-bit helpers
// used by ps2_device.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_HI,
    TX_LO,
    RX_WAIT,
    RX_HI,
    RX_LO,
    RX_ACK,
    HOLDOFF
  } ps2_state_t;

  localparam logic        PS2_START = 1'b0;
  localparam logic        PS2_STOP  = 1'b1;
  localparam int unsigned FRAME_LEN = 11;

  // Parity bit that makes the 9-bit data+parity group contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit idx (0..10) of a device-to-host frame: start, data LSB first, parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic b;
    if (idx == 4'd0)      b = PS2_START;
    else if (idx <= 4'd8) b = d[3'(idx - 4'd1)];
    else if (idx == 4'd9) b = odd_parity(d);
    else                  b = PS2_STOP;
    return b;
  endfunction

endpackage

// File: rtl/ps2_dev_fifo.sv
// Transmit byte FIFO for ps2_device: depth 2**AW x 8 bits.
// Ports: clk, reset (sync, active-high), din/push (write, dropped when full),
// pop (ignored when empty), head (registered copy of the oldest byte),
// full, empty.
module ps2_dev_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       push,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // head tracks the next byte out: incoming byte when the FIFO is (or
      // becomes) empty, otherwise the following stored entry after a pop.
      if (do_push && (empty || (count == (AW + 1)'(1) && do_pop))) begin
        head <= din;
      end else if (do_pop && count > (AW + 1)'(1)) begin
        head <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: rtl/ps2_device.sv
// PS/2 device-side link (keyboard/mouse end) for one channel.
// Sends queued bytes as device-to-host frames on a self-generated PS/2 clock
// and receives host-to-device command bytes with ACK.
// Ports: clk, reset (sync, active-high); tx_data/tx_valid/tx_ready (byte
// queue input); rx_data/rx_valid/rx_err (received byte, 1-cycle strobe,
// error qualifier); busy (line FSM active); ps2_clk_i/ps2_data_i (lines as
// seen); ps2_clk_o/ps2_data_o (open-collector drives, 1 = release).
module ps2_device
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 573,
  parameter int unsigned IDLE_MIN = 573,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  input  logic       ps2_data_i,
  output logic       ps2_data_o
);

  localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_MIN + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [3:0]       TX_LAST   = 4'(FRAME_LEN - 1);
  localparam logic [3:0]       RX_LAST   = 4'd9;

  ps2_state_t        state;
  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              clk_s;
  logic              data_s;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_ok;
  logic [1:0]        rts_cnt;
  logic              rts;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_done;
  logic [3:0]        bit_idx;
  logic [9:0]        rx_sh;
  logic [9:0]        rx_next;
  logic              rx_pend;
  logic              pend_err;
  logic [7:0]        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  ps2_dev_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (tx_data),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready = !fifo_full;
  assign busy     = (state != IDLE);
  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign idle_ok  = (idle_cnt == IDLE_W'(IDLE_MIN));
  assign div_done = (div_cnt == HALF_LAST);
  assign fifo_pop = (state == TX_LO) && div_done && (bit_idx == TX_LAST);
  assign rx_next  = {data_s, rx_sh[9:1]};
  // Three consecutive synced-low cycles: data released just after an aborted
  // transmit can still read low for two cycles and must not look like RTS.
  assign rts      = (state == IDLE) && !clk_s && !data_s && (rts_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      idle_cnt  <= '0;
      rts_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      if (clk_s && data_s) begin
        if (!idle_ok) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
      if (state == IDLE && !clk_s && !data_s) begin
        if (rts_cnt != 2'd2) rts_cnt <= rts_cnt + 1'b1;
      end else begin
        rts_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
      div_cnt    <= '0;
      bit_idx    <= '0;
      rx_sh      <= '0;
      rx_pend    <= 1'b0;
      pend_err   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      if (rx_pend) begin
        rx_data <= rx_sh[7:0];
        rx_err  <= pend_err;
      end
      div_cnt <= div_cnt + 1'b1;
      case (state)
        IDLE: begin
          ps2_clk_o  <= 1'b1;
          ps2_data_o <= 1'b1;
          div_cnt    <= '0;
          bit_idx    <= '0;
          if (rts) begin
            state <= RX_WAIT;
          end else if (!fifo_empty && idle_ok) begin
            state      <= TX_HI;
            ps2_data_o <= frame_bit(head, 4'd0);
          end
        end
        TX_HI: begin
          // Our own clock release takes two cycles to reach clk_s, so a low
          // seen in the first two cycles of the high phase is not an inhibit.
          if (!clk_s && div_cnt >= DIV_W'(2) && bit_idx < TX_LAST) begin
            state      <= IDLE;
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b1;
            div_cnt    <= '0;
          end else if (div_done) begin
            state     <= TX_LO;
            ps2_clk_o <= 1'b0;
            div_cnt   <= '0;
          end
        end
        TX_LO: begin
          if (div_done) begin
            div_cnt   <= '0;
            ps2_clk_o <= 1'b1;
            if (bit_idx == TX_LAST) begin
              state      <= HOLDOFF;
              ps2_data_o <= 1'b1;
            end else begin
              state      <= TX_HI;
              bit_idx    <= bit_idx + 4'd1;
              ps2_data_o <= frame_bit(head, bit_idx + 4'd1);
            end
          end
        end
        RX_WAIT: begin
          div_cnt <= '0;
          if (clk_s) begin
            state     <= RX_LO;
            ps2_clk_o <= 1'b0;
            bit_idx   <= '0;
          end
        end
        RX_LO: begin
          if (div_done) begin
            state     <= RX_HI;
            ps2_clk_o <= 1'b1;
            div_cnt   <= '0;
          end
        end
        RX_HI: begin
          if (div_done) begin
            div_cnt <= '0;
            rx_sh   <= rx_next;
            if (bit_idx == RX_LAST) begin
              if (data_s == PS2_STOP) begin
                state      <= RX_ACK;
                ps2_data_o <= 1'b0;
              end else begin
                state    <= HOLDOFF;
                rx_pend  <= 1'b1;
                pend_err <= 1'b1;
              end
            end else begin
              state     <= RX_LO;
              ps2_clk_o <= 1'b0;
              bit_idx   <= bit_idx + 4'd1;
            end
          end
        end
        RX_ACK: begin
          if (div_cnt == HALF_LAST) ps2_clk_o <= 1'b0;
          if (div_cnt == FULL_LAST) begin
            state      <= HOLDOFF;
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b1;
            div_cnt    <= '0;
            rx_pend    <= 1'b1;
            pend_err   <= (odd_parity(rx_sh[7:0]) != rx_sh[8]);
          end
        end
        HOLDOFF: begin
          ps2_clk_o  <= 1'b1;
          ps2_data_o <= 1'b1;
          if (div_done) begin
            state   <= IDLE;
            div_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: a host model drives the lines, a scoreboard queue
// holds expected transmit bytes and received commands, and a monitor decodes
// device frames and rx strobes against them.
module tb_ps2_device;

  localparam int CD = 8;
  localparam int IM = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;
  logic       ps2_clk_i;
  logic       ps2_clk_o;
  logic       ps2_data_i;
  logic       ps2_data_o;
  logic       host_clk;
  logic       host_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_tx[$];
  logic [8:0] exp_rx[$];
  int         tx_nbits = 0;
  bit         rx_active = 1'b0;

  // monitor-owned state
  int          low_len = 0;
  int          high_len = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic        prev_valid = 1'b0;
  logic [10:0] fbits = '0;

  assign ps2_clk_i  = host_clk & ps2_clk_o;
  assign ps2_data_i = host_data & ps2_data_o;

  always #5 clk = ~clk;

  ps2_device #(.CLK_DIV(CD), .IDLE_MIN(IM), .FIFO_AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_i (ps2_data_i),
    .ps2_data_o (ps2_data_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, bit making total ones odd, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Monitor: decodes device frames from the drive outputs and checks rx strobes.
  always @(negedge clk) begin
    if (reset) begin
      tx_nbits = 0;
      low_len  = 0;
      high_len = 0;
      prev_clk = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk_o) begin
        low_len = 1;
        if (!rx_active) begin
          chk("tx_data_stable_at_fall", ps2_data_o, prev_data);
          fbits[tx_nbits] = ps2_data_o;
          tx_nbits++;
          if (tx_nbits == 11) begin
            tx_nbits = 0;
            if (exp_tx.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_unexpected_frame: got frame %03h, expected none", fbits);
            end else begin
              chk("tx_frame", 32'(fbits), 32'(model_frame(exp_tx.pop_front())));
            end
          end
        end
      end else if (!ps2_clk_o) begin
        low_len++;
      end else if (!prev_clk && ps2_clk_o) begin
        chk("clk_low_len", low_len, CD);
        high_len = 1;
      end else begin
        high_len++;
        if (tx_nbits != 0 && high_len > CD + 2) tx_nbits = 0;
      end
      if (rx_valid) begin
        if (prev_valid) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_width: got 2+ cycles, expected 1");
        end
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h err %0b, expected none", rx_data, rx_err);
        end else begin
          chk("rx_result", 32'({rx_err, rx_data}), 32'(exp_rx.pop_front()));
        end
      end
      prev_valid = rx_valid;
      prev_clk   = ps2_clk_o;
      prev_data  = ps2_data_o;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    chk("tx_ready", tx_ready, (exp_tx.size() < 16) ? 1 : 0);
    tx_data  = b;
    tx_valid = 1'b1;
    if (exp_tx.size() < 16) exp_tx.push_back(b);
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_tx.size() != 0 || busy) timeout_fail("tx_drain");
  endtask

  task automatic wait_clk_o(input logic lvl, input string name);
    int n = 0;
    while (ps2_clk_o !== lvl && n < 8 * CD) begin
      tick(1);
      n++;
    end
    if (ps2_clk_o !== lvl) timeout_fail(name);
  endtask

  task automatic host_send(input logic [7:0] b, input bit bad_par, input bit stop);
    logic [9:0] bv;
    logic       par;
    bit         ack_seen;
    int         n;
    par = ($countones(b) % 2 == 0) ^ bad_par;
    bv  = {stop, par, b};
    exp_rx.push_back({bad_par || !stop, b});
    rx_active = 1'b1;
    host_clk  = 1'b0;
    tick(4);
    host_data = 1'b0;
    tick(10);
    host_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk_o(1'b0, "rx_clk_fall");
      tick(2);
      host_data = bv[i];
      wait_clk_o(1'b1, "rx_clk_rise");
    end
    ack_seen = 1'b0;
    for (int i = 0; i < 3 * CD; i++) begin
      if (ps2_data_o == 1'b0) ack_seen = 1'b1;
      tick(1);
    end
    chk("rx_ack_presence", ack_seen, stop);
    host_data = 1'b1;
    n = 0;
    while (busy && n < 8 * CD) begin
      tick(1);
      n++;
    end
    if (busy) timeout_fail("rx_finish");
    tick(3);
    rx_active = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    host_clk  = 1'b1;
    host_data = 1'b1;
    tick(3);
    chk("reset_clk_o", ps2_clk_o, 1);
    chk("reset_data_o", ps2_data_o, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_err", rx_err, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_ready", tx_ready, 1);
    reset = 1'b0;
    tick(2);

    // single byte on idle lines
    push_byte(8'h1C);
    wait_drain(1000);

    // fill while inhibited, overflow dropped, then drain in order
    host_clk = 1'b0;
    tick(5);
    for (int i = 0; i < 17; i++) push_byte(8'h30 + 8'(i));
    chk("tx_ready_full", tx_ready, 0);
    tick(3);
    chk("busy_while_inhibited", busy, 0);
    host_clk = 1'b1;
    wait_drain(16 * 400);

    // inhibit during bit 4, frame must be resent in full
    push_byte(8'hF0);
    n = 0;
    while (!(tx_nbits == 4 && ps2_clk_o == 1'b1) && n < 1000) begin
      tick(1);
      n++;
    end
    if (!(tx_nbits == 4 && ps2_clk_o == 1'b1)) timeout_fail("reach_bit4");
    tick(CD / 2);
    host_clk = 1'b0;
    tick(3);
    chk("abort_busy", busy, 0);
    chk("abort_clk_o", ps2_clk_o, 1);
    chk("abort_data_o", ps2_data_o, 1);
    tick(30);
    host_clk = 1'b1;
    wait_drain(1000);

    // host commands
    host_send(8'hED, 1'b0, 1'b1);
    host_send(8'hED, 1'b1, 1'b1);
    host_send(8'h5C, 1'b0, 1'b0);

    // randomized mix
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        if (exp_tx.size() < 15) push_byte(8'($urandom));
        tick($urandom_range(0, 40));
      end
      wait_drain(3000);
      host_send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    // reset in the middle of a transmit
    push_byte(8'hA5);
    push_byte(8'h5A);
    n = 0;
    while (tx_nbits < 3 && n < 1000) begin
      tick(1);
      n++;
    end
    if (tx_nbits < 3) timeout_fail("reach_mid_tx");
    reset = 1'b1;
    tick(1);
    chk("midreset_clk_o", ps2_clk_o, 1);
    chk("midreset_data_o", ps2_data_o, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_tx_ready", tx_ready, 1);
    reset = 1'b0;
    exp_tx.delete();
    tick(IM * 4);
    chk("fifo_empty_after_reset", busy, 0);

    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
